div_iter_unit: RTL and testbench

Iterative signed 32-bit divider datapath for the processor's multdiv unit. It latches operands on a `ctrl_DIV` start pulse and performs one restoring shift-subtract step per clock. It returns the quotient with a one-cycle ready pulse 33 cycles after start, which is the same latency as the multdiv result-ready counter. The multdiv output mux and the pipeline stall logic downstream consume `data_result`, `data_exception` and `data_resultRDY`.

---
 rtl/div_iter_unit_pkg.sv | 15 +
 rtl/div_iter_unit_if.sv | 40 ++++
 rtl/div_iter_unit_step.sv | 26 ++
 rtl/div_iter_unit.sv | 153 +++++++++++++++
 tb/tb_div_iter_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/div_iter_unit_pkg.sv
// Shared types and constants for the iterative signed divider.
// Holds the FSM state encoding and the default datapath width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_RESULT = 32'h8000_0000;

endpackage

// File: rtl/div_iter_unit_if.sv
// Start/operand/result bundle between the multdiv control and the divider.
// master drives operands and start/abort strobes; slave is the divider.
interface div_iter_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             ctrl_DIV;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV,
    output ctrl_MULT,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_DIV,
    input  ctrl_MULT,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/div_iter_unit_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Purely combinational; the caller owns all state.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // The dividend MSB enters the remainder as the quotient register shifts left.
    r_shift = {r_in, q_in[WIDTH-1]};
    diff    = r_shift - {1'b0, b_mag};
    fits    = ~diff[WIDTH];
    r_out   = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_out   = {q_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed divider: latches operands on ctrl_DIV, runs WIDTH restoring
// steps, then registers the quotient with a one-cycle ready pulse.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  div_iter_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (rem_q),
    .q_in  (quo_q),
    .b_mag (bmag_q),
    .r_out (step_rem),
    .q_out (step_quo)
  );

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_mag = bus.data_operandA[WIDTH-1] ? ('0 - bus.data_operandA) : bus.data_operandA;
    b_mag = bus.data_operandB[WIDTH-1] ? ('0 - bus.data_operandB) : bus.data_operandB;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
        if (div0_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else if (ovf_q) begin
          result_d = MIN_VAL;
          exc_d    = 1'b1;
        end else begin
          result_d = neg_q ? ('0 - quo_q) : quo_q;
          exc_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort or restart discards whatever the FSM was about to finish,
    // including a result that DONE would otherwise have published.
    if (bus.ctrl_MULT) begin
      state_d  = IDLE;
      rdy_d    = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
    end else if (bus.ctrl_DIV) begin
      state_d  = RUN;
      rdy_d    = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = a_mag;
      bmag_d   = b_mag;
      neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div0_d   = (bus.data_operandB == '0);
      ovf_d    = (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      bmag_q   <= bmag_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a table of signed divides plus
// restart, abort, reset and back-to-back sequences.
module tb_div_iter_unit;
  import div_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_iter_unit_if #(.WIDTH(DIV_WIDTH)) bus ();

  div_iter_unit #(.WIDTH(DIV_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; the start is sampled at the next posedge (E0) and
  // the task returns at the negedge following E0.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    step_cycle();
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
  endtask

  // Samples from the negedge after E0 (k=0) through the negedge after E40.
  task automatic wait_result(output int busy_cnt, output int rdy_edge, output int rdy_cnt,
                             output logic [31:0] res, output logic exc);
    busy_cnt = 0;
    rdy_edge = -1;
    rdy_cnt  = 0;
    res      = '0;
    exc      = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step_cycle();
      if (bus.busy) busy_cnt++;
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (rdy_edge < 0) begin
          rdy_edge = k;
          res      = bus.data_result;
          exc      = bus.data_exception;
        end
      end
    end
  endtask

  vec_t        vecs [12];
  int          busy_cnt, rdy_edge, rdy_cnt;
  logic [31:0] res;
  logic        exc;

  initial begin
    vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0};
    vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  1'b0};
    vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         1'b0};
    vecs[4]  = '{32'd7,          32'd100,        32'd0,          1'b0};
    vecs[5]  = '{32'd1234,       32'd0,          32'd0,          1'b1};
    vecs[6]  = '{DIV_OVF_RESULT, 32'hFFFF_FFFF,  DIV_OVF_RESULT, 1'b1};
    vecs[7]  = '{DIV_OVF_RESULT, 32'd1,          DIV_OVF_RESULT, 1'b0};
    vecs[8]  = '{32'h7FFF_FFFF,  DIV_OVF_RESULT, 32'd0,          1'b0};
    vecs[9]  = '{DIV_OVF_RESULT, DIV_OVF_RESULT, 32'd1,          1'b0};
    vecs[10] = '{-32'sd7,        32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[11] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};

    reset_n           = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", 32'(bus.data_exception), 32'd0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    step_cycle();

    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b);
      wait_result(busy_cnt, rdy_edge, rdy_cnt, res, exc);
      $display("div %h / %h -> result %h exc %0d ready_edge %0d busy_cycles %0d",
               vecs[i].a, vecs[i].b, res, exc, rdy_edge, busy_cnt);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_exc", i), 32'(exc), 32'(vecs[i].exc));
      check($sformatf("vec%0d_rdy_edge", i), 32'(rdy_edge), 32'd33);
      check($sformatf("vec%0d_rdy_count", i), 32'(rdy_cnt), 32'd1);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'd32);
    end

    // Restart: 9/3 issued at E10 of 100/7 replaces it entirely.
    start_div(32'd100, 32'd7);
    repeat (9) step_cycle();
    start_div(32'd9, 32'd3);
    wait_result(busy_cnt, rdy_edge, rdy_cnt, res, exc);
    $display("restart 9 / 3 -> result %h ready_edge %0d ready_count %0d", res, rdy_edge, rdy_cnt);
    check("restart_rdy_edge", 32'(rdy_edge), 32'd33);
    check("restart_rdy_count", 32'(rdy_cnt), 32'd1);
    check("restart_result", res, 32'd3);
    check("restart_busy_cycles", 32'(busy_cnt), 32'd32);

    // Abort with ctrl_MULT at E5: no ready, previous result held.
    start_div(32'd100, 32'd7);
    repeat (4) step_cycle();
    bus.ctrl_MULT = 1'b1;
    step_cycle();
    bus.ctrl_MULT = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result_held", bus.data_result, 32'd3);
    wait_result(busy_cnt, rdy_edge, rdy_cnt, res, exc);
    $display("abort 100 / 7 at E5 -> ready_count %0d busy_cycles %0d", rdy_cnt, busy_cnt);
    check("abort_rdy_count", 32'(rdy_cnt), 32'd0);
    check("abort_busy_cycles", 32'(busy_cnt), 32'd0);

    // Asynchronous reset in the middle of RUN at E20.
    start_div(32'd100, 32'd7);
    repeat (19) step_cycle();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_result", bus.data_result, 32'd0);
    check("midrun_reset_exc", 32'(bus.data_exception), 32'd0);
    check("midrun_reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("midrun_reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_result(busy_cnt, rdy_edge, rdy_cnt, res, exc);
    $display("reset at E20 -> ready_count %0d busy_cycles %0d", rdy_cnt, busy_cnt);
    check("post_reset_rdy_count", 32'(rdy_cnt), 32'd0);
    check("post_reset_busy_cycles", 32'(busy_cnt), 32'd0);

    // Back-to-back: 81/9 is sampled on the edge where 50/5's ready is high.
    start_div(32'd50, 32'd5);
    repeat (33) step_cycle();
    check("b2b_first_rdy", 32'(bus.data_resultRDY), 32'd1);
    check("b2b_first_result", bus.data_result, 32'd10);
    $display("b2b 50 / 5 -> result %h ready %0d", bus.data_result, bus.data_resultRDY);
    start_div(32'd81, 32'd9);
    check("b2b_rdy_dropped", 32'(bus.data_resultRDY), 32'd0);
    check("b2b_result_held", bus.data_result, 32'd10);
    check("b2b_second_busy", 32'(bus.busy), 32'd1);
    wait_result(busy_cnt, rdy_edge, rdy_cnt, res, exc);
    $display("b2b 81 / 9 -> result %h ready_edge %0d", res, rdy_edge);
    check("b2b_second_rdy_edge", 32'(rdy_edge), 32'd33);
    check("b2b_second_result", res, 32'd9);
    check("b2b_second_rdy_count", 32'(rdy_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
